ysyx_22041412_alu_arb: RTL and testbench

//  Two-requester arbiter/sequencer for the shared combinational ALU (opcode/func3/func7/scr1/scr2 -> result).
//  Req0 = EXU integer ops, req1 = LSU address generation (load/store -> UADD).

---
 rtl/ysyx_22041412_alu_arb.sv | 144 ++++++++++++++
 tb/tb_ysyx_22041412_alu_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_alu_arb.sv
// Two-requester arbiter/sequencer for the shared combinational ALU.
// Req0 = EXU integer ops, req1 = LSU address generation.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   reqN_valid/ready         N=0,1 request handshake
//   reqN_opcode/func3/func7  ALU control fields of request N
//   reqN_src1/src2/tag       operands and echoed tag of request N
//   alu_opcode..alu_scr2     to shared ALU, zero when nothing granted
//   alu_result               from ALU, combinational on alu_*
//   rspN_valid/ready         N=0,1 response handshake
//   rsp_result/rsp_tag       registered response shared by both channels
//   op_cnt                   accepted-request counter, wraps to 0
//
// Config macro YSYX_22041412_ALU_ARB_FIXED_PRIO_EN: when defined req0
// always wins a tie; otherwise ties are resolved round-robin.
module ysyx_22041412_alu_arb #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_opcode,
    input  logic [2:0]       req0_func3,
    input  logic             req0_func7,
    input  logic [63:0]      req0_src1,
    input  logic [63:0]      req0_src2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_opcode,
    input  logic [2:0]       req1_func3,
    input  logic             req1_func7,
    input  logic [63:0]      req1_src1,
    input  logic [63:0]      req1_src2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [6:0]       alu_opcode,
    output logic [2:0]       alu_func3,
    output logic             alu_func7,
    output logic [63:0]      alu_scr1,
    output logic [63:0]      alu_scr2,
    input  logic [63:0]      alu_result,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [63:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_cnt
);

    logic             rsp_vld_q,    rsp_vld_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [63:0]      rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
    logic [CNT_W-1:0] op_cnt_q,     op_cnt_d;
    logic             last_gnt_q,   last_gnt_d;

    logic gnt_vld;
    logic gnt;
    logic rsp_fire;
    logic can_accept;
    logic accept;

    // State register: response slot, owner, counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            op_cnt_q     <= '0;
            last_gnt_q   <= 1'b1;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            op_cnt_q     <= op_cnt_d;
            last_gnt_q   <= last_gnt_d;
        end
    end

    // Grant and next-state logic.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
`ifdef YSYX_22041412_ALU_ARB_FIXED_PRIO_EN
        gnt = ~req0_valid;
`else
        // A tie goes to whoever did not win the last accepted op.
        gnt = (req0_valid & req1_valid) ? ~last_gnt_q : req1_valid;
`endif
        rsp_fire   = rsp_vld_q & (rsp_id_q ? rsp1_ready : rsp0_ready);
        // The slot may be refilled in the same cycle it drains.
        can_accept = ~rsp_vld_q | rsp_fire;
        accept     = rst_n & gnt_vld & can_accept;

        rsp_vld_d    = rsp_vld_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        op_cnt_d     = op_cnt_q;
        last_gnt_d   = last_gnt_q;

        if (accept) begin
            rsp_vld_d    = 1'b1;
            rsp_id_d     = gnt;
            rsp_result_d = alu_result;
            rsp_tag_d    = gnt ? req1_tag : req0_tag;
            op_cnt_d     = op_cnt_q + 1'b1;
            last_gnt_d   = gnt;
        end else if (rsp_fire) begin
            rsp_vld_d = 1'b0;
        end
    end

    // Output logic.
    always_comb begin
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;

        alu_opcode = '0;
        alu_func3  = '0;
        alu_func7  = 1'b0;
        alu_scr1   = '0;
        alu_scr2   = '0;
        if (gnt_vld) begin
            alu_opcode = gnt ? req1_opcode : req0_opcode;
            alu_func3  = gnt ? req1_func3  : req0_func3;
            alu_func7  = gnt ? req1_func7  : req0_func7;
            alu_scr1   = gnt ? req1_src1   : req0_src1;
            alu_scr2   = gnt ? req1_src2   : req0_src2;
        end

        rsp0_valid = rsp_vld_q & ~rsp_id_q;
        rsp1_valid = rsp_vld_q & rsp_id_q;
        rsp_result = rsp_result_q;
        rsp_tag    = rsp_tag_q;
        op_cnt     = op_cnt_q;
    end

endmodule

// File: tb/tb_ysyx_22041412_alu_arb.sv
// Testbench for ysyx_22041412_alu_arb: directed cases then a random
// phase with a response scoreboard and a reference ALU.
module tb_ysyx_22041412_alu_arb;

    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0] req0_opcode, req1_opcode, alu_opcode;
    logic [2:0] req0_func3, req1_func3, alu_func3;
    logic req0_func7, req1_func7, alu_func7;
    logic [63:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [63:0] alu_scr1, alu_scr2, alu_result, rsp_result;
    logic [TAG_W-1:0] req0_tag, req1_tag, rsp_tag;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [CNT_W-1:0] op_cnt;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ysyx_22041412_alu_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opcode(req0_opcode), .req0_func3(req0_func3),
        .req0_func7(req0_func7), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opcode(req1_opcode), .req1_func3(req1_func3),
        .req1_func7(req1_func7), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_tag(req1_tag),
        .alu_opcode(alu_opcode), .alu_func3(alu_func3),
        .alu_func7(alu_func7), .alu_scr1(alu_scr1),
        .alu_scr2(alu_scr2), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .op_cnt(op_cnt)
    );

    function automatic logic [63:0] alu_ref(input logic [6:0] op,
        input logic [2:0] f3, input logic f7,
        input logic [63:0] a, input logic [63:0] b);
        logic [31:0] w;
        case (op)
            7'h33: case (f3)
                3'd4:    return a ^ b;
                3'd6:    return a | b;
                3'd7:    return a & b;
                default: return f7 ? a - b : a + b;
            endcase
            7'h13, 7'h03, 7'h23: return a + b;
            7'h3b: begin
                w = f7 ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
                return {{32{w[31]}}, w};
            end
            default: return 64'd0;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_opcode, alu_func3, alu_func7,
                                     alu_scr1, alu_scr2);

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [6:0] op,
        input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
        req0_valid = v; req0_opcode = op; req0_func3 = 3'd0;
        req0_func7 = 1'b0; req0_src1 = a; req0_src2 = b; req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [6:0] op,
        input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
        req1_valid = v; req1_opcode = op; req1_func3 = 3'd0;
        req1_func7 = 1'b0; req1_src1 = a; req1_src2 = b; req1_tag = t;
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 7'h33;
            1: return 7'h13;
            2: return 7'h03;
            3: return 7'h23;
            default: return 7'h3b;
        endcase
    endfunction

    task automatic rand0();
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_opcode = rand_op(); req0_func3 = 3'($urandom);
        req0_func7 = 1'($urandom);
        req0_src1 = {$urandom, $urandom}; req0_src2 = {$urandom, $urandom};
        req0_tag = 4'($urandom);
    endtask

    task automatic rand1();
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_opcode = rand_op(); req1_func3 = 3'($urandom);
        req1_func7 = 1'($urandom);
        req1_src1 = {$urandom, $urandom}; req1_src2 = {$urandom, $urandom};
        req1_tag = 4'($urandom);
    endtask

    localparam int NRAND = 400;

    // Random-phase driver with its own arbitration model; pushes the
    // expected response of every accepted request.
    task automatic driver();
        logic full = 1'b0;
        logic owner = 1'b0;
        logic last = 1'b1;
        logic [CNT_W-1:0] cnt = '0;
        logic acc0 = 1'b1;
        logic acc1 = 1'b1;
        for (int i = 0; i < NRAND + 3; i++) begin
            logic fire, can, w, any;
            exp_t e;
            if (i >= NRAND) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            end else begin
                if (!req0_valid || acc0) rand0();
                if (!req1_valid || acc1) rand1();
                rsp0_ready = ($urandom_range(0, 2) != 0);
                rsp1_ready = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            #1;
            fire = full & (owner ? rsp1_ready : rsp0_ready);
            can = ~full | fire;
            any = req0_valid | req1_valid;
`ifdef YSYX_22041412_ALU_ARB_FIXED_PRIO_EN
            w = !req0_valid;
`else
            w = (req0_valid && req1_valid) ? !last : req1_valid;
`endif
            chk("rnd_ready0", 64'(req0_ready), 64'(any & can & !w));
            chk("rnd_ready1", 64'(req1_ready), 64'(any & can & w));
            chk("rnd_op_cnt", 64'(op_cnt), 64'(cnt));
            if (!any) chk("rnd_alu_idle", alu_scr1 | 64'(alu_opcode), 64'd0);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            if (any && can) begin
                e.id = w;
                e.tag = w ? req1_tag : req0_tag;
                e.res = w ? alu_ref(req1_opcode, req1_func3, req1_func7,
                                    req1_src1, req1_src2)
                          : alu_ref(req0_opcode, req0_func3, req0_func7,
                                    req0_src1, req0_src2);
                sb.push_back(e);
                full = 1'b1; owner = w; last = w; cnt = cnt + 1'b1;
            end else if (fire) begin
                full = 1'b0;
            end
            cyc();
        end
    endtask

    // Random-phase monitor: compares the presented response with the
    // scoreboard head and pops it on a handshake.
    task automatic monitor();
        for (int i = 0; i < NRAND + 3; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("mon_rsp_idle", 64'({rsp0_valid, rsp1_valid}), 64'd0);
            end else begin
                chk("mon_rsp0_valid", 64'(rsp0_valid), 64'(!sb[0].id));
                chk("mon_rsp1_valid", 64'(rsp1_valid), 64'(sb[0].id));
                chk("mon_result", rsp_result, sb[0].res);
                chk("mon_tag", 64'(rsp_tag), 64'(sb[0].tag));
                if ((rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready))
                    void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b1, 7'h33, 64'd1, 64'd1, 4'd0);
        set1(1'b1, 7'h33, 64'd1, 64'd1, 4'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_op_cnt", 64'(op_cnt), 64'd0);
        chk("rst_result", rsp_result, 64'd0);
        chk("rst_tag", 64'(rsp_tag), 64'd0);
        rst_n = 1'b1;
        set0(1'b0, 7'h33, 64'd0, 64'd0, 4'd0);
        set1(1'b0, 7'h33, 64'd0, 64'd0, 4'd0);
        cyc();

        // ADD 5+7 on req0
        set0(1'b1, 7'h33, 64'd5, 64'd7, 4'd3);
        @(negedge clk);
        chk("add_ready0", 64'(req0_ready), 64'd1);
        chk("add_ready1", 64'(req1_ready), 64'd0);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("add_rsp0_valid", 64'(rsp0_valid), 64'd1);
        chk("add_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("add_result", rsp_result, 64'd12);
        chk("add_tag", 64'(rsp_tag), 64'd3);
        chk("add_op_cnt", 64'(op_cnt), 64'd1);
        cyc();

        // LSU address generation on req1
        set1(1'b1, 7'h03, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 4'd5);
        @(negedge clk);
        chk("ld_ready1", 64'(req1_ready), 64'd1);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("ld_rsp1_valid", 64'(rsp1_valid), 64'd1);
        chk("ld_result", rsp_result, 64'h7FFF_FFF8);
        chk("ld_tag", 64'(rsp_tag), 64'd5);
        cyc();

        // Back-pressure: req1 waits while rsp0 is stalled
        set0(1'b1, 7'h33, 64'd1, 64'd2, 4'd1);
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready0", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid = 1'b0;
        set1(1'b1, 7'h33, 64'd10, 64'd20, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready1_low", 64'(req1_ready), 64'd0);
            chk("bp_rsp0_held", 64'(rsp0_valid), 64'd1);
            chk("bp_result_held", rsp_result, 64'd3);
            cyc();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready1_drain", 64'(req1_ready), 64'd1);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
        chk("bp_rsp0_gone", 64'(rsp0_valid), 64'd0);
        chk("bp_result", rsp_result, 64'd30);
        chk("bp_op_cnt", 64'(op_cnt), 64'd4);
        cyc();

        // Both valid every cycle: last winner was req1, so req0 goes first
        set0(1'b1, 7'h13, 64'd100, 64'd1, 4'd6);
        set1(1'b1, 7'h13, 64'd200, 64'd1, 4'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef YSYX_22041412_ALU_ARB_FIXED_PRIO_EN
            chk("tie_ready0", 64'(req0_ready), 64'd1);
`else
            chk("tie_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            chk("tie_ready1", 64'(req1_ready), 64'(i % 2 == 1));
`endif
            chk("tie_op_cnt", 64'(op_cnt), 64'(4 + i));
            cyc();
        end

        // Reset while the response register is full
        req1_valid = 1'b0;
        set0(1'b1, 7'h33, 64'd9, 64'd9, 4'd9);
        @(negedge clk);
        chk("mid_ready0", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid = 1'b0;
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("mid_full", 64'(rsp0_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        chk("mid_rst_op_cnt", 64'(op_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        fork
            driver();
            monitor();
        join
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
